// File: rtl/timer_ctrl_fsm.sv
// Countdown timer controller: prescaled tick generator plus a 4-state
// IDLE/RUN/PAUSE/DONE controller with registered status outputs.
module timer_ctrl_fsm #(
  parameter int DIV    = 500000,
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [1:0]        state,
  output logic              is_counting,
  output logic              tick,
  output logic              sec_clk,
  output logic [TIME_W-1:0] remaining,
  output logic              done,
  output logic              alarm
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t              state_reg, state_next;
  logic [PRE_W-1:0]    pre_reg, pre_next;
  logic [TIME_W-1:0]   rem_reg, rem_next;
  logic                sec_clk_reg, sec_clk_next;
  logic                tick_reg, done_reg, alarm_reg, is_counting_reg;
  logic                wrap;

  always_comb begin
    state_next   = state_reg;
    pre_next     = pre_reg;
    rem_next     = rem_reg;
    sec_clk_next = sec_clk_reg;
    wrap         = (state_reg == S_RUN) && (pre_reg == PRE_MAX);
    case (state_reg)
      S_IDLE: begin
        if (stop) begin
          pre_next = '0;
        end else if (load) begin
          rem_next     = load_val;
          pre_next     = '0;
          sec_clk_next = 1'b0;
        end else if (start && rem_reg != '0) begin
          state_next = S_RUN;
          pre_next   = '0;
        end
      end
      S_RUN: begin
        // A wrap always lands, even alongside stop/pause; expiry beats both.
        if (wrap) begin
          pre_next     = '0;
          sec_clk_next = ~sec_clk_reg;
          if (rem_reg <= TIME_W'(1)) begin
            rem_next   = '0;
            state_next = S_DONE;
          end else begin
            rem_next = rem_reg - TIME_W'(1);
            if (stop)       state_next = S_IDLE;
            else if (pause) state_next = S_PAUSE;
          end
        end else if (stop) begin
          state_next = S_IDLE;
          pre_next   = '0;
        end else if (pause) begin
          state_next = S_PAUSE;
        end else begin
          pre_next = pre_reg + PRE_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_next = S_IDLE;
          pre_next   = '0;
        end else if (load) begin
          state_next   = S_IDLE;
          rem_next     = load_val;
          pre_next     = '0;
          sec_clk_next = 1'b0;
        end else if (!pause && start) begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (stop) begin
          state_next = S_IDLE;
          pre_next   = '0;
        end else if (load) begin
          state_next   = S_IDLE;
          rem_next     = load_val;
          pre_next     = '0;
          sec_clk_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pre_reg         <= '0;
      rem_reg         <= '0;
      sec_clk_reg     <= 1'b0;
      tick_reg        <= 1'b0;
      done_reg        <= 1'b0;
      alarm_reg       <= 1'b0;
      is_counting_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pre_reg         <= pre_next;
      rem_reg         <= rem_next;
      sec_clk_reg     <= sec_clk_next;
      tick_reg        <= wrap;
      done_reg        <= wrap && (state_next == S_DONE);
      alarm_reg       <= (state_next == S_DONE);
      is_counting_reg <= (state_next == S_RUN);
    end
  end

  assign state       = state_reg;
  assign is_counting = is_counting_reg;
  assign tick        = tick_reg;
  assign sec_clk     = sec_clk_reg;
  assign remaining   = rem_reg;
  assign done        = done_reg;
  assign alarm       = alarm_reg;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Bench for timer_ctrl_fsm (DIV=4, TIME_W=4): directed scenarios with literal
// expectations plus randomized commands, all checked every cycle against a model.
module tb_timer_ctrl_fsm;
  localparam int DIV    = 4;
  localparam int TIME_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, pause, stop, load;
  logic [TIME_W-1:0] load_val;
  logic [1:0]        state;
  logic              is_counting, tick, sec_clk, done, alarm;
  logic [TIME_W-1:0] remaining;

  timer_ctrl_fsm #(.DIV(DIV), .TIME_W(TIME_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .load(load), .load_val(load_val), .state(state),
    .is_counting(is_counting), .tick(tick), .sec_clk(sec_clk),
    .remaining(remaining), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0=IDLE 1=RUN 2=PAUSE 3=DONE; cnt = RUN cycles elapsed in current tick.
  int m_mode, m_cnt, m_rem, m_sec, m_tick, m_done;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_load(input int lv);
    m_mode = 0; m_rem = lv; m_cnt = 0; m_sec = 0;
  endtask

  task automatic model_step(input int r, sa, pa, so, lo, lv);
    m_tick = 0; m_done = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_rem = 0; m_sec = 0;
    end else begin
      case (m_mode)
        0: if (so) m_cnt = 0;
           else if (lo) do_load(lv);
           else if (sa && m_rem > 0) begin m_mode = 1; m_cnt = 0; end
        1: begin
          if (m_cnt == DIV - 1) begin
            m_cnt = 0; m_tick = 1; m_sec = 1 - m_sec;
            if (m_rem > 0) m_rem = m_rem - 1;
            if (m_rem == 0) begin m_mode = 3; m_done = 1; end
            else if (so) m_mode = 0;
            else if (pa) m_mode = 2;
          end else if (so) begin m_mode = 0; m_cnt = 0; end
          else if (pa) m_mode = 2;
          else m_cnt = m_cnt + 1;
        end
        2: if (so) begin m_mode = 0; m_cnt = 0; end
           else if (lo) do_load(lv);
           else if (!pa && sa) m_mode = 1;
        default: if (so) begin m_mode = 0; m_cnt = 0; end
                 else if (lo) do_load(lv);
      endcase
    end
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_mode);
    chk("is_counting", int'(is_counting), int'(m_mode == 1));
    chk("tick", int'(tick), m_tick);
    chk("sec_clk", int'(sec_clk), m_sec);
    chk("remaining", int'(remaining), m_rem);
    chk("done", int'(done), m_done);
    chk("alarm", int'(alarm), int'(m_mode == 3));
  endtask

  // Drive one cycle's inputs at the falling edge, advance the model, then
  // compare on the next falling edge.
  task automatic cyc(input int r, sa, pa, so, lo, lv);
    rst = r[0]; start = sa[0]; pause = pa[0]; stop = so[0]; load = lo[0];
    load_val = TIME_W'(lv);
    model_step(r, sa, pa, so, lo, lv);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  int tick_cnt, done_at, first_tick;

  initial begin
    rst = 1; start = 0; pause = 0; stop = 0; load = 0; load_val = '0;
    m_mode = 0; m_cnt = 0; m_rem = 0; m_sec = 0; m_tick = 0; m_done = 0;
    @(negedge clk);
    cyc(1, 1, 1, 0, 1, 7);
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_remaining", int'(remaining), 0);

    // Basic countdown from 3: ticks every 4 cycles, done with the third tick.
    cyc(0, 0, 0, 0, 1, 3);
    cyc(0, 1, 0, 0, 0, 0);
    chk("lit_run_state", int'(state), 1);
    tick_cnt = 0; done_at = -1;
    for (int k = 0; k < 12; k++) begin
      idle_cyc();
      if (tick) begin
        tick_cnt++;
        $display("tick %0d at cycle %0d remaining=%0d", tick_cnt, k, remaining);
      end
      if (done) done_at = k;
    end
    chk("lit_tick_count", tick_cnt, 3);
    chk("lit_done_cycle", done_at, 11);
    chk("lit_done_state", int'(state), 3);
    chk("lit_alarm", int'(alarm), 1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("lit_done_ignores_start", int'(state), 3);

    // Pause after two prescaler counts, hold, resume: tick two cycles later.
    cyc(0, 0, 0, 0, 1, 5);
    chk("lit_load_from_done", int'(state), 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle_cyc(); idle_cyc();
    cyc(0, 0, 1, 0, 0, 0);
    tick_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (tick) tick_cnt++;
    end
    chk("lit_paused_ticks", tick_cnt, 0);
    chk("lit_paused_state", int'(state), 2);
    cyc(0, 1, 0, 0, 0, 0);
    first_tick = -1;
    for (int k = 0; k < 4; k++) begin
      idle_cyc();
      if (tick && first_tick < 0) first_tick = k;
    end
    chk("lit_resume_tick", first_tick, 1);

    // stop+pause on a non-wrap cycle: IDLE, remaining held, full tick on restart.
    cyc(0, 0, 1, 1, 0, 0);
    chk("lit_stop_state", int'(state), 0);
    chk("lit_stop_remaining", int'(remaining), 4);
    cyc(0, 1, 0, 0, 0, 0);
    first_tick = -1;
    for (int k = 0; k < 5; k++) begin
      idle_cyc();
      if (tick && first_tick < 0) first_tick = k;
    end
    chk("lit_restart_tick", first_tick, 3);

    // remaining=1 with pause on the wrap cycle: DONE wins.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0);
    idle_cyc(); idle_cyc(); idle_cyc();
    cyc(0, 0, 1, 0, 0, 0);
    chk("lit_wrap_pause_state", int'(state), 3);
    chk("lit_wrap_pause_done", int'(done), 1);
    chk("lit_wrap_pause_rem", int'(remaining), 0);

    // load 0 then start stays IDLE; load inside RUN is ignored.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("lit_zero_start", int'(state), 0);
    cyc(0, 0, 0, 0, 1, 5);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 9);
    chk("lit_run_load_ignored", int'(remaining), 5);

    // Reset in RUN at remaining=2 clears everything next cycle.
    for (int k = 0; k < 14 && remaining != 2; k++) idle_cyc();
    chk("lit_reached_rem2", int'(remaining), 2);
    idle_cyc();
    cyc(1, 1, 0, 0, 0, 0);
    chk("lit_rst_state", int'(state), 0);
    chk("lit_rst_sec_clk", int'(sec_clk), 0);
    chk("lit_rst_remaining", int'(remaining), 0);

    // Randomized command mix.
    for (int k = 0; k < 3000; k++) begin
      int r, sa, pa, so, lo, lv;
      r  = int'($urandom_range(0, 199) == 0);
      so = int'($urandom_range(0, 24) == 0);
      lo = int'($urandom_range(0, 14) == 0);
      pa = int'($urandom_range(0, 11) == 0);
      sa = int'($urandom_range(0, 2) == 0);
      lv = int'($urandom_range(0, 15));
      cyc(r, sa, pa, so, lo, lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_fsm.md
TIMER_CTRL_FSM -- requirements
Module: timer_ctrl_fsm

Interface
REQ-001 SHALL have parameter DIV, default 500000: clk cycles per tick, minimum 2.
REQ-002 SHALL have parameter TIME_W, default 8: width of the countdown value, minimum 2.
REQ-003 SHALL have derived local PRE_W = clog2(DIV): prescaler width.
REQ-004 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: begin or resume countdown (level sampled each cycle).
REQ-007 SHALL have port pause, input, 1: suspend countdown.
REQ-008 SHALL have port stop, input, 1: abort to IDLE.
REQ-009 SHALL have port load, input, 1: load load_val into remaining.
REQ-010 SHALL have port load_val, input, TIME_W: countdown start value in ticks.
REQ-011 SHALL have port state, output, 2: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 SHALL have port is_counting, output, 1: high iff state==RUN.
REQ-013 SHALL have port tick, output, 1: one-cycle pulse per completed tick.
REQ-014 SHALL have port sec_clk, output, 1: square wave toggling on every tick.
REQ-015 SHALL have port remaining, output, TIME_W: ticks left.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on expiry.
REQ-017 SHALL have port alarm, output, 1: level, high while state==DONE.
REQ-018 All outputs SHALL be registered; no combinational input-to-output paths.

Function
REQ-019 Prescaler SHALL increment only in RUN, counting 0..DIV-1, then wrapping to 0 ("wrap").
REQ-020 On wrap: tick=1 for the following cycle; sec_clk toggles; remaining decrements by 1.
REQ-021 On a wrap with remaining==1: remaining becomes 0, state becomes DONE, done=1 for one cycle, alarm=1.
REQ-022 IDLE: start with remaining!=0 -> RUN with prescaler=0; start with remaining==0 is ignored.
REQ-023 RUN: stop -> IDLE, prescaler cleared, remaining held; else pause -> PAUSE, prescaler held.
REQ-024 PAUSE: stop -> IDLE, prescaler cleared; else start -> RUN, resuming from the held prescaler value.
REQ-025 DONE: stop or load -> IDLE, alarm cleared; start and pause are ignored.
REQ-026 Command priority SHALL be rst > stop > load > pause > start.
REQ-027 load SHALL be accepted in IDLE, PAUSE and DONE: remaining=load_val, prescaler=0, sec_clk=0, state=IDLE; load in RUN is ignored.
REQ-028 A wrap and pause/stop in the same RUN cycle: the wrap SHALL take effect (tick, decrement, possible DONE) and DONE takes precedence over PAUSE/IDLE.
REQ-029 remaining SHALL never decrement below 0 or wrap.
REQ-030 sec_clk SHALL hold its level outside RUN.
REQ-031 DIV SHALL be configurable at instantiation with no change to port widths.

Reset
REQ-032 On rst: state=IDLE, prescaler=0, remaining=0, tick=0, sec_clk=0, done=0, alarm=0, is_counting=0.
REQ-033 rst mid-operation SHALL override all inputs in the same cycle.

Verification (DIV=4, TIME_W=4)
REQ-034 rst, load_val=3, load, then start -> RUN; tick pulses every 4 cycles; remaining goes 3,2,1,0; done pulse coincides with the third tick; state=DONE; alarm=1.
REQ-035 RUN with remaining=5, pause after 2 prescaler counts, hold 10 cycles, then start -> no tick while paused; next tick exactly 2 RUN cycles after resume.
REQ-036 stop and pause asserted together in RUN on a non-wrap cycle -> state=IDLE, prescaler=0, remaining unchanged; subsequent start restarts a full 4-cycle tick.
REQ-037 remaining=1, pause asserted on the wrap cycle -> done pulse, state=DONE (not PAUSE), remaining=0.
REQ-038 load_val=0, load, start -> state stays IDLE, no tick; load in RUN with load_val=9 -> ignored, remaining unaffected.
REQ-039 rst asserted in RUN at remaining=2 -> next cycle all outputs at reset values; sec_clk=0.
